// File: rtl/uart_slip_rx.sv
// uart_slip_rx: SLIP deframer with length check and a show-ahead output FIFO.
// Optional CRC-8 trailer check is enabled by defining SLIP_CRC_EN.
module uart_slip_rx #(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       received,
    input  logic       recv_error,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [7:0] C_END   = 8'hC0;
    localparam logic [7:0] C_ESC   = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;

`ifdef SLIP_CRC_EN
    localparam logic [1:0] HOLD_N = 2'd2;
`else
    localparam logic [1:0] HOLD_N = 2'd1;
`endif

    typedef enum logic [1:0] {
        S_HUNT,
        S_DATA,
        S_ESC
    } state_t;

    state_t state;
    state_t next_state;

    // holdback: hold_old is always the oldest held byte
    logic [7:0]    hold_old;
    logic [1:0]    hold_cnt;
    logic [LW-1:0] dec_cnt;

`ifdef SLIP_CRC_EN
    logic [7:0] hold_new;
    logic [7:0] crc;
    logic [7:0] crc_push;
    logic       short_frame;
`endif

    // terminator waiting for FIFO space
    logic       term_pend;
    logic [7:0] term_data;

    // registered FIFO write request
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_err;

    // FIFO storage and pointers
    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [AW+1:0] count_next;
    logic [9:0]  head;
    logic        full;
    logic        rd_fire;
    logic        fifo_push;
    logic        space;

    // decoder decisions for this cycle
    logic       dec_ok;
    logic [7:0] dec_val;
    logic       is_end;
    logic       bad;
    logic       take;
    logic       push;
    logic       term;
    logic       term_bad;
    logic       pulse_ok;
    logic       pulse_err;
    logic       set_ovf;
    logic       clear;

`ifdef SLIP_CRC_EN
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    assign crc_push = crc8(crc, hold_old);
`endif

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == (AW+1)'(DEPTH));
    assign out_valid  = (count != '0);
    assign rd_fire    = out_valid & out_ready;
    assign fifo_push  = wr_en & (~full | rd_fire);
    // occupancy seen by a write issued from this cycle's decision
    assign count_next = {1'b0, count} + (AW+2)'(wr_en) - (AW+2)'(rd_fire);
    assign space      = (count_next < (AW+2)'(DEPTH));

    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_data = out_valid ? head[7:0] : 8'h00;
    assign out_last = out_valid ? head[8] : 1'b0;
    assign out_err  = out_valid ? head[9] : 1'b0;

    // Decode the incoming byte and decide holdback, FIFO and pulse actions
    always_comb begin
        next_state = state;
        dec_ok     = 1'b0;
        dec_val    = rx_byte;
        is_end     = 1'b0;
        bad        = 1'b0;
        take       = 1'b0;
        push       = 1'b0;
        term       = 1'b0;
        term_bad   = 1'b0;
        pulse_ok   = 1'b0;
        pulse_err  = 1'b0;
        set_ovf    = 1'b0;
        clear      = 1'b0;
`ifdef SLIP_CRC_EN
        short_frame = 1'b0;
`endif
        if (!term_pend) begin
            if (recv_error && state != S_HUNT) begin
                bad = 1'b1;
            end else if (received) begin
                unique case (state)
                    S_HUNT: begin
                        if (rx_byte == C_END) next_state = S_DATA;
                    end
                    S_DATA: begin
                        if (rx_byte == C_END) is_end = 1'b1;
                        else if (rx_byte == C_ESC) next_state = S_ESC;
                        else dec_ok = 1'b1;
                    end
                    S_ESC: begin
                        next_state = S_DATA;
                        if (rx_byte == ESC_END) begin
                            dec_ok  = 1'b1;
                            dec_val = C_END;
                        end else if (rx_byte == ESC_ESC) begin
                            dec_ok  = 1'b1;
                            dec_val = C_ESC;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: next_state = S_HUNT;
                endcase
            end
        end

        if (dec_ok) begin
            if (dec_cnt == LW'(MAX_LEN)) begin
                bad = 1'b1;
            end else if (hold_cnt == HOLD_N && !space) begin
                bad     = 1'b1;
                set_ovf = 1'b1;
            end else begin
                take = 1'b1;
                push = (hold_cnt == HOLD_N);
            end
        end

        if (is_end && hold_cnt != 2'd0) begin
`ifdef SLIP_CRC_EN
            if (hold_cnt != 2'd2) begin
                bad         = 1'b1;
                short_frame = 1'b1;
            end else if (crc_push != hold_new) begin
                bad = 1'b1;
            end else if (!space) begin
                bad = 1'b1;
            end else begin
                term     = 1'b1;
                pulse_ok = 1'b1;
                clear    = 1'b1;
            end
`else
            if (!space) begin
                bad = 1'b1;
            end else begin
                term     = 1'b1;
                pulse_ok = 1'b1;
                clear    = 1'b1;
            end
`endif
        end

        if (bad) begin
            next_state = S_HUNT;
            take       = 1'b0;
            push       = 1'b0;
            pulse_ok   = 1'b0;
            pulse_err  = 1'b1;
            clear      = 1'b1;
            term_bad   = 1'b1;
`ifdef SLIP_CRC_EN
            term = (hold_cnt != 2'd0) && !short_frame;
`else
            term = (hold_cnt != 2'd0);
`endif
        end
    end

    // Decoder state, holdback, pending terminator and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HUNT;
            hold_old  <= 8'h00;
            hold_cnt  <= 2'd0;
            dec_cnt   <= '0;
            term_pend <= 1'b0;
            term_data <= 8'h00;
            wr_en     <= 1'b0;
            wr_data   <= 8'h00;
            wr_last   <= 1'b0;
            wr_err    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
`ifdef SLIP_CRC_EN
            hold_new  <= 8'h00;
            crc       <= 8'h00;
`endif
        end else begin
            state     <= next_state;
            frame_ok  <= pulse_ok;
            frame_err <= pulse_err;
            wr_en     <= 1'b0;
            if (set_ovf) overflow <= 1'b1;

            if (term_pend) begin
                if (space) begin
                    wr_en     <= 1'b1;
                    wr_data   <= term_data;
                    wr_last   <= 1'b1;
                    wr_err    <= 1'b1;
                    term_pend <= 1'b0;
                end
            end else if (push || term) begin
                if (space) begin
                    wr_en   <= 1'b1;
                    wr_data <= hold_old;
                    wr_last <= term;
                    wr_err  <= term_bad;
                end else begin
                    term_pend <= 1'b1;
                    term_data <= hold_old;
                end
            end

            if (clear) begin
                hold_cnt <= 2'd0;
                dec_cnt  <= '0;
`ifdef SLIP_CRC_EN
                crc      <= 8'h00;
`endif
            end else if (take) begin
                dec_cnt <= dec_cnt + 1'b1;
`ifdef SLIP_CRC_EN
                if (push) begin
                    crc      <= crc_push;
                    hold_old <= hold_new;
                    hold_new <= dec_val;
                end else begin
                    if (hold_cnt == 2'd0) hold_old <= dec_val;
                    else hold_new <= dec_val;
                    hold_cnt <= hold_cnt + 2'd1;
                end
`else
                hold_old <= dec_val;
                if (!push) hold_cnt <= hold_cnt + 2'd1;
`endif
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (fifo_push) mem[wr_ptr[AW-1:0]] <= {wr_err, wr_last, wr_data};
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: doc/uart_slip_rx.md
# uart_slip_rx

SLIP deframer on the receive side of the host UART link: takes the per-byte `rx_byte`/`received`/`recv_error` strobes from the `uart` receiver and removes END/ESC framing. It checks frame length and an optional CRC-8, then buffers decoded payload bytes with frame boundaries in a show-ahead FIFO for the command logic. It is the receive-side counterpart to the trace framing that the transmit side sends.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, at least 4.
- `MAX_LEN`, 64: maximum decoded bytes per frame, including the CRC byte when CRC is enabled.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_byte` in 8: byte from the UART receiver; valid while `received`=1.
- `received` in 1: one-cycle byte strobe.
- `recv_error` in 1: one-cycle UART framing-error strobe.
- `out_data` out 8: head-of-FIFO payload byte.
- `out_last` out 1: head byte is the final byte of its frame.
- `out_err` out 1: qualifies `out_last`; the frame ended in error and must be discarded.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head entry when `out_valid` & `out_ready`.
- `frame_ok` out 1: one-cycle pulse when a good frame terminator is written.
- `frame_err` out 1: one-cycle pulse on any frame error.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full; cleared only by `rst`.

## Operation
- Byte codes:
  - END = 0xC0.
  - ESC = 0xDB.
  - ESC 0xDC decodes to 0xC0; ESC 0xDD decodes to 0xDB.
- Decoder states:
  - HUNT (reset state): discard all bytes until END, then go to DATA.
  - DATA:
    - END terminates the frame.
    - ESC goes to ESC.
    - Any other byte is a decoded byte.
  - ESC: 0xDC or 0xDD gives a decoded byte and returns to DATA; any other byte is an invalid escape, which is an error.
- Holdback: decoded bytes pass through a holdback register before the FIFO, so that `last` can attach to the final byte. The holdback is 1 byte deep (2 with CRC enabled).
  - On each new decoded byte, the oldest held byte is written to the FIFO with last=0.
- Good END: the held byte is written with last=1, err=0, and `frame_ok` pulses.
  - END with no decoded bytes (END END) is ignored, with no pulses.
- Errors: invalid escape, `recv_error` while in DATA or ESC, decoded count > `MAX_LEN`, FIFO full on write, or CRC mismatch.
  - `frame_err` pulses.
  - If any byte of the frame has been decoded, one terminator entry (the oldest held byte, last=1, err=1) is written; the rest of the holdback is discarded.
  - The decoder then goes to HUNT.
  - `recv_error` in HUNT is ignored.
- FIFO full: the incoming byte is dropped, `overflow` is set and the frame errors.
  - The terminator is held pending until space frees.
  - While a terminator is pending, all input is discarded and the decoder stays in HUNT.
- FIFO: pointers are log2(`DEPTH`)+1 bits and wrap naturally. A simultaneous write and read at full is a legal write.

## Timing
- Reset values:
  - `out_valid`=0, `frame_ok`=0, `frame_err`=0, `overflow`=0.
  - `out_data`, `out_last` and `out_err` are 0 while the FIFO is empty.
  - Decoder in HUNT, holdback empty, CRC register 0x00.
- `rst` mid-frame: all state is discarded, including FIFO contents and any pending terminator.
- Latency:
  - The FIFO write happens in the cycle after the `received` strobe that pushes a byte out of the holdback, or after the END that terminates the frame.
  - `out_valid` asserts in the cycle after that write.
- `frame_ok` and `frame_err` assert in the same cycle as the terminator write. When the terminator is pending, `frame_err` asserts at error detection.
- Accepts one byte per clock; `received` spacing of 1 cycle is legal.

## Configuration
- `SLIP_CRC_EN` defined:
  - The last decoded byte of each frame is a CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over the preceding payload bytes.
  - The CRC byte is never written to the FIFO; the running CRC updates on each byte leaving the holdback.
  - Mismatch is an error.
  - A frame with only 1 decoded byte is an error, with nothing written.
- `SLIP_CRC_EN` undefined: every decoded byte is payload, with no CRC logic and a 1-deep holdback.

## Test plan
- Reset, then feed `C0 01 C0` with `out_ready`=1 (no CRC) -> single entry `01`, last=1, err=0; `frame_ok` pulses once; `frame_err` stays 0.
- Feed `C0 DB DC DB DD 05 C0` -> entries `C0`, `DB`, `05`, with last=1 only on `05`.
- With `SLIP_CRC_EN`:
  - Feed `C0 01 02 1B C0` -> entries `01`, `02` (last on `02`, err=0) and `frame_ok`.
  - Feed `C0 01 02 1C C0` -> the same entries, `02` has last=1, err=1, `frame_err` pulses.
- Feed `C0 01 DB 41 07 C0` -> entry `01` with last=1, err=1, `frame_err` pulses; `07` is discarded. The next frame `C0 09 C0`, sent after that closing `C0`, decodes normally.
- Hold `out_ready`=0 and send 20 payload bytes (`DEPTH`=16) followed by `C0` -> `overflow`=1 and `frame_err` pulses. After `out_ready` is released, the FIFO drains 16 entries and then the pending terminator with last=1, err=1.
